// File: rtl/rs_enc_pkg.sv
// Shared definitions for the RS(K+4,K) t=2 encoder/decoder blocks over GF(2^8).
// Holds the field polynomial, the generator coefficients and the encoder FSM encoding.
package rs_enc_pkg;

    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam logic [7:0] G3      = 8'h0F;
    localparam logic [7:0] G2      = 8'h36;
    localparam logic [7:0] G1      = 8'h78;
    localparam logic [7:0] G0      = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10
    } enc_state_e;

    // Multiply by alpha (x) modulo the field polynomial.
    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        gf_xtime = {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

endpackage

// File: rtl/rs_gf_const_mul.sv
// Combinational GF(2^8) multiply by a constant C: an XOR network of the
// shifted constant selected by the bits of the operand.
module rs_gf_const_mul
    import rs_enc_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] i_a,
    output logic [7:0] o_p
);

    logic [7:0] acc_s;
    logic [7:0] pw_s;

    // Sum C*x^i over the set bits of i_a; pw_s walks C, C*x, C*x^2, ...
    always_comb begin
        acc_s = 8'h00;
        pw_s  = C;
        for (int i = 0; i < 8; i++) begin
            if (i_a[i]) begin
                acc_s = acc_s ^ pw_s;
            end else begin
                acc_s = acc_s;
            end
            pw_s = gf_xtime(pw_s);
        end
    end

    assign o_p = acc_s;

endmodule

// File: rtl/rs_enc_parity_gen.sv
// Systematic RS(K+4,K) encoder: forwards K data bytes one cycle late, then
// shifts out the four LFSR remainder bytes r3..r0 as parity.
module rs_enc_parity_gen
    import rs_enc_pkg::*;
#(
    parameter int K = 28
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_frame_sync,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_sync,
    output logic       o_parity,
    output logic       o_last,
    output logic       o_sync_err
);

    localparam int             CW       = $clog2(K + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(K - 1);

    enc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pcnt_q, pcnt_d;
    logic [7:0]    r3_q, r2_q, r1_q, r0_q;
    logic [7:0]    r3_d, r2_d, r1_d, r0_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          sync_q, sync_d;
    logic          parity_q, parity_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic          ready_s, accept_s, fb_s;
    logic [7:0]    r3_g_s, r2_g_s, r1_g_s, r0_g_s, f_s;
    logic [7:0]    m3_s, m2_s, m1_s, m0_s;

    assign ready_s  = (state_q != ST_PARITY);
    assign accept_s = i_valid & ready_s;

    // A sync byte (or any byte in IDLE) starts from an all-zero remainder.
    assign fb_s   = (state_q == ST_DATA) & ~i_frame_sync;
    assign r3_g_s = fb_s ? r3_q : 8'h00;
    assign r2_g_s = fb_s ? r2_q : 8'h00;
    assign r1_g_s = fb_s ? r1_q : 8'h00;
    assign r0_g_s = fb_s ? r0_q : 8'h00;
    assign f_s    = i_data ^ r3_g_s;

    rs_gf_const_mul #(.C(G3)) u_mul_g3 (.i_a(f_s), .o_p(m3_s));
    rs_gf_const_mul #(.C(G2)) u_mul_g2 (.i_a(f_s), .o_p(m2_s));
    rs_gf_const_mul #(.C(G1)) u_mul_g1 (.i_a(f_s), .o_p(m1_s));
    rs_gf_const_mul #(.C(G0)) u_mul_g0 (.i_a(f_s), .o_p(m0_s));

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && i_frame_sync) begin
                    state_d = (K == 1) ? ST_PARITY : ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (accept_s && i_frame_sync) begin
                    state_d = (K == 1) ? ST_PARITY : ST_DATA;
                end else if (accept_s && (cnt_q == CNT_LAST)) begin
                    state_d = ST_PARITY;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (pcnt_q == 2'd3) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values.
    always_comb begin
        cnt_d    = cnt_q;
        pcnt_d   = pcnt_q;
        r3_d     = r3_q;
        r2_d     = r2_q;
        r1_d     = r1_q;
        r0_d     = r0_q;
        data_d   = 8'h00;
        valid_d  = 1'b0;
        sync_d   = 1'b0;
        parity_d = 1'b0;
        last_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept_s && (i_frame_sync || (state_q == ST_DATA))) begin
                    r3_d    = r2_g_s ^ m3_s;
                    r2_d    = r1_g_s ^ m2_s;
                    r1_d    = r0_g_s ^ m1_s;
                    r0_d    = m0_s;
                    cnt_d   = i_frame_sync ? CNT_ONE : (cnt_q + CNT_ONE);
                    data_d  = i_data;
                    valid_d = 1'b1;
                    sync_d  = i_frame_sync;
                    err_d   = i_frame_sync && (state_q == ST_DATA);
                end else if (accept_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
                end
                pcnt_d = 2'd0;
            end
            ST_PARITY: begin
                data_d   = r3_q;
                valid_d  = 1'b1;
                parity_d = 1'b1;
                last_d   = (pcnt_q == 2'd3);
                r3_d     = r2_q;
                r2_d     = r1_q;
                r1_d     = r0_q;
                r0_d     = 8'h00;
                pcnt_d   = pcnt_q + 2'd1;
                cnt_d    = {CW{1'b0}};
            end
            default: begin
                pcnt_d = 2'd0;
                cnt_d  = {CW{1'b0}};
            end
        endcase
    end

    // Datapath and registered output flops.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            cnt_q    <= {CW{1'b0}};
            pcnt_q   <= 2'd0;
            r3_q     <= 8'h00;
            r2_q     <= 8'h00;
            r1_q     <= 8'h00;
            r0_q     <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            sync_q   <= 1'b0;
            parity_q <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
            r3_q     <= r3_d;
            r2_q     <= r2_d;
            r1_q     <= r1_d;
            r0_q     <= r0_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sync_q   <= sync_d;
            parity_q <= parity_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign o_ready    = ready_s;
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_sync     = sync_q;
    assign o_parity   = parity_q;
    assign o_last     = last_q;
    assign o_sync_err = err_q;

endmodule

// File: tb/tb_rs_enc_parity_gen.sv
// Directed bench for rs_enc_parity_gen (K=28): hand-computed parity vectors,
// syndrome evaluation of captured codewords, gaps, sync errors and mid-parity reset.
module tb_rs_enc_parity_gen;

    typedef logic [7:0] cw_t [28];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       i_frame_sync = 1'b0;
    logic       o_ready, o_valid, o_sync, o_parity, o_last, o_sync_err;
    logic [7:0] o_data;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int glitch = 0;
    int run = 0;
    int last_run = 0;
    logic [7:0] cap_d[$];
    logic [2:0] cap_f[$];
    logic [7:0] ref_d[$];

    rs_enc_parity_gen #(.K(28)) dut (
        .i_clk(clk), .i_res(rst), .i_data(i_data), .i_valid(i_valid),
        .i_frame_sync(i_frame_sync), .o_ready(o_ready), .o_data(o_data),
        .o_valid(o_valid), .o_sync(o_sync), .o_parity(o_parity),
        .o_last(o_last), .o_sync_err(o_sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Syndrome s_j of cap_d[start +: 32], first byte = highest power.
    function automatic logic [7:0] synd(input int j, input int start);
        logic [7:0] s, aj;
        s  = 8'h00;
        aj = 8'(1 << j);
        for (int i = 0; i < 32; i++) s = gmul(s, aj) ^ cap_d[start + i];
        return s;
    endfunction

    task automatic chk_synd(input string tag, input int start);
        for (int j = 0; j < 4; j++) chk($sformatf("%s_s%0d", tag, j), 32'(synd(j, start)), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                cap_d.push_back(o_data);
                cap_f.push_back({o_sync, o_parity, o_last});
            end else if (o_sync || o_parity || o_last) begin
                glitch++;
            end
            if (o_sync_err) err_cnt++;
            if (!o_ready) run++;
            else begin
                if (run != 0) last_run = run;
                run = 0;
            end
        end
    end

    task automatic clear_cap();
        cap_d.delete();
        cap_f.delete();
        err_cnt = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        int n;
        i_valid = 1'b1;
        i_data = d;
        i_frame_sync = s;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        i_frame_sync = 1'b0;
    endtask

    task automatic send_cw(input cw_t d, input bit gaps);
        for (int i = 0; i < 28; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) repeat ($urandom_range(1, 3)) @(negedge clk);
            send(d[i], (i == 0));
        end
    endtask

    task automatic flush();
        repeat (8) @(negedge clk);
    endtask

    cw_t zero_cw, one_cw, rnd_cw;
    int  mism, nlast;

    initial begin
        for (int i = 0; i < 28; i++) begin
            zero_cw[i] = 8'h00;
            one_cw[i]  = 8'h00;
            rnd_cw[i]  = 8'($urandom_range(0, 255));
        end
        one_cw[27] = 8'h01;

        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_err", 32'(o_sync_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: all-zero data
        clear_cap();
        send_cw(zero_cw, 1'b0);
        flush();
        chk("t1_len", 32'(cap_d.size()), 32'd32);
        mism = 0;
        nlast = 0;
        foreach (cap_d[i]) if (cap_d[i] != 8'h00) mism++;
        foreach (cap_f[i]) if (cap_f[i][0]) nlast++;
        chk("t1_zero_bytes", 32'(mism), 32'd0);
        chk("t1_sync_first", 32'(cap_f[0]), 32'b100);
        chk("t1_last_flag", 32'(cap_f[31]), 32'b011);
        chk("t1_parity_start", 32'(cap_f[28]), 32'b010);
        chk("t1_data_end", 32'(cap_f[27]), 32'b000);
        chk("t1_last_count", 32'(nlast), 32'd1);
        chk("t1_ready_low", 32'(last_run), 32'd4);

        // 2: single 0x01 in the last data byte gives the generator coefficients
        clear_cap();
        send_cw(one_cw, 1'b0);
        flush();
        chk("t2_len", 32'(cap_d.size()), 32'd32);
        chk("t2_d27", 32'(cap_d[27]), 32'h01);
        chk("t2_p0", 32'(cap_d[28]), 32'h0F);
        chk("t2_p1", 32'(cap_d[29]), 32'h36);
        chk("t2_p2", 32'(cap_d[30]), 32'h78);
        chk("t2_p3", 32'(cap_d[31]), 32'h40);

        // 3: random data, syndromes vanish; a corrupted byte does not
        clear_cap();
        send_cw(rnd_cw, 1'b0);
        flush();
        chk("t3_len", 32'(cap_d.size()), 32'd32);
        mism = 0;
        for (int i = 0; i < 28; i++) if (cap_d[i] != rnd_cw[i]) mism++;
        chk("t3_forward", 32'(mism), 32'd0);
        chk_synd("t3", 0);
        ref_d = cap_d;
        cap_d[5] = cap_d[5] ^ 8'h5A;
        chk("t3_flip_s0_nonzero", 32'(synd(0, 0) != 8'h00), 32'd1);

        // 4: same data with gaps, then a back-to-back codeword held through the ready-low window
        clear_cap();
        send_cw(rnd_cw, 1'b1);
        send_cw(one_cw, 1'b0);
        flush();
        chk("t4_len", 32'(cap_d.size()), 32'd64);
        mism = 0;
        for (int i = 0; i < 32; i++) if (cap_d[i] != ref_d[i]) mism++;
        chk("t4_stream", 32'(mism), 32'd0);
        chk("t4_b2b_sync", 32'(cap_f[32]), 32'b100);
        chk("t4_b2b_p0", 32'(cap_d[60]), 32'h0F);
        chk("t4_b2b_p3", 32'(cap_d[63]), 32'h40);
        chk("t4_ready_low", 32'(last_run), 32'd4);

        // 5: drop in IDLE, then abort at byte 10
        clear_cap();
        send(8'hAA, 1'b0);
        flush();
        chk("t5_drop_len", 32'(cap_d.size()), 32'd0);
        chk("t5_drop_err", 32'(err_cnt), 32'd1);
        for (int i = 0; i < 9; i++) send(8'(i + 1), (i == 0));
        send_cw(rnd_cw, 1'b0);
        flush();
        chk("t5_abort_err", 32'(err_cnt), 32'd2);
        chk("t5_len", 32'(cap_d.size()), 32'd41);
        chk("t5_resync_flag", 32'(cap_f[9]), 32'b100);
        chk("t5_last_flag", 32'(cap_f[40]), 32'b011);
        chk_synd("t5", 9);

        // 6: reset during the second parity byte
        clear_cap();
        send_cw(zero_cw, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_in_parity", 32'(o_parity), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(o_valid), 32'd0);
        chk("t6_data", 32'(o_data), 32'd0);
        chk("t6_parity", 32'(o_parity), 32'd0);
        chk("t6_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_cap();
        send_cw(one_cw, 1'b0);
        flush();
        chk("t6_len", 32'(cap_d.size()), 32'd32);
        chk("t6_p0", 32'(cap_d[28]), 32'h0F);
        chk("t6_p1", 32'(cap_d[29]), 32'h36);
        chk("t6_p2", 32'(cap_d[30]), 32'h78);
        chk("t6_p3", 32'(cap_d[31]), 32'h40);

        chk("flags_without_valid", 32'(glitch), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
